pcm_i2s_receiver: RTL and testbench
===================================

Name: pcm_i2s_receiver

Overview:
- Deserialises the external I2S ADC/receiver stream (bck, lrck, sdata) into parallel 24-bit left/right samples.
- Emits the one-clk `pcm_valid` strobe plus `l_pcm_data`/`r_pcm_data` consumed by the front-end test mux in PCM bypass.
- Runs on the 49.152 MHz mclk domain; the I2S pins are asynchronous and oversampled after synchronisation.

Parameters:
- DATA_WIDTH, 24, output sample width; bits captured per slot, MSB first.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for bck, lrck and sdata (minimum 2).
- MAX_SLOT, 32, largest supported slot length in bck cycles; sizes the bit counter.

Ports:
- clk  in  1  mclk 49.152 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  cpu enable; low = synchronous clear of datapath and FSM.
- i2s_bck  in  1  external bit clock, asynchronous, at most clk/4.
- i2s_lrck  in  1  external word select: 0 = left, 1 = right.
- i2s_sdata  in  1  external serial data.
- pcm_valid  out  1  one-clk strobe; new L/R pair on the data outputs.
- l_pcm_data  out  24  left sample, two's complement, held between strobes.
- r_pcm_data  out  24  right sample, two's complement, held between strobes.
- slot_err  out  1  sticky slot-length error (see Optional Feature).

Behaviour:
- Reset (reset_n low, async): all outputs 0, FSM = ALIGN, shift registers and counters 0. The same clear applies synchronously while run = 0.
- Synchronisation: SYNC_STAGES-deep synchroniser on each of the three pins.
  - bck rise is detected as synced bck = 1 with the previous synced bck = 0.
  - All lrck/sdata sampling happens in the clk cycle of that detected rise.
- I2S framing: 1-bit delay.
  - On a bck rise where the sampled lrck differs from the previous sampled lrck, the sdata bit sampled is the last bit of the outgoing slot.
  - The next bck rise carries the MSB of the new slot.
- Bit counter: 0 at slot start, incremented per bck rise, saturating at MAX_SLOT.
  - While count < DATA_WIDTH, sdata is shifted into the channel shift register (MSB first).
  - Bits beyond DATA_WIDTH are ignored, which supports 32-bit slots.
- Short slots: if fewer than DATA_WIDTH bits arrive before the lrck change, the remaining LSBs are 0 (left-justified into 24 bits).
- FSM states:
  - ALIGN: wait for the first lrck 1->0 change, which starts a left slot. Produces no output. Go to LEFT.
  - LEFT: capture the left word. On an lrck 0->1 change, latch the shift register into an internal left holding register. Go to RIGHT.
  - RIGHT: capture the right word. On an lrck 1->0 change:
    - the left holding register goes to l_pcm_data;
    - the right shift register goes to r_pcm_data;
    - pcm_valid = 1 for exactly one clk;
    - go to LEFT.
- Latency: pcm_valid and the new data appear on the clk edge after the clk cycle in which the bck rise that detects lrck 1->0 is seen.
  - The data outputs update in the same cycle pcm_valid rises.
  - The data outputs are never updated without pcm_valid.
- run falling mid-frame: the partial frame is discarded, no strobe is issued, and the FSM returns to ALIGN. run rising starts alignment afresh, so the first pcm_valid needs at least one full L/R frame.
- lrck stuck or bck stopped: no strobe, outputs hold their last values.

Optional Feature:
- Macro: PCM_SLOT_ERR_EN.
- Defined:
  - slot_err is set, sticky, when any completed slot had fewer than DATA_WIDTH bits.
  - slot_err is also set when a completed right slot's bit count differs from the preceding left slot's.
  - slot_err is cleared only by reset_n low or run = 0.
  - Samples are still delivered (zero-padded) when slot_err is set.
- Undefined: slot_err is tied to 0 and no slot-length comparison logic is built.

Test Plan:
- Reset and alignment: reset_n low, then run = 1; 64-fs stream, 32-bit slots, L = 0x123456, R = 0xABCDEF. Outputs stay 0 until the first full frame; then pcm_valid pulses once per frame with l = 0x123456, r = 0xABCDEF; pulse width is exactly 1 clk.
- Bit-ordering and sign: L = 0x800000, R = 0x7FFFFF, 32-bit slots. Outputs are exactly 0x800000 / 0x7FFFFF. Trailing slot bits are set to 1 and are ignored.
- Short slot: 16-bit slots, L = 0xBEEF, R = 0x1234. l = 0xBEEF00, r = 0x123400; with PCM_SLOT_ERR_EN, slot_err = 1 after the first frame and remains 1.
- Run drop mid-frame: run = 0 during the 10th bit of a right slot, held 5 clk, then re-raised. No pcm_valid for the broken frame; the next valid pair is correct; slot_err = 0.
- Max rate: bck = clk/4 (12.288 MHz, 192 kHz × 64) for 100 frames of random data. Every frame matches the scoreboard; the pcm_valid count is 100 minus alignment frames.
- Async reset: reset_n asserted between clk edges mid-slot. All outputs are 0 immediately, without waiting for a clk edge; FSM is in ALIGN after release.

Source files
------------

// File: rtl/pcm_i2s_receiver.sv
// I2S (1-bit delay) to parallel L/R PCM deserialiser; define PCM_SLOT_ERR_EN to build slot-length checking.
// Latency: strobe 1 clk after the synced bck rise that closes the right slot; no backpressure, outputs held.
`timescale 1ns/1ps
module pcm_i2s_receiver #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_SLOT    = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  input  logic                  i2s_bck,
  input  logic                  i2s_lrck,
  input  logic                  i2s_sdata,
  output logic                  pcm_valid,
  output logic [DATA_WIDTH-1:0] l_pcm_data,
  output logic [DATA_WIDTH-1:0] r_pcm_data,
  output logic                  slot_err
);

  localparam int CW = $clog2(MAX_SLOT + 1);

  typedef enum logic [1:0] {ALIGN, LEFT, RIGHT} state_t;

  logic [SYNC_STAGES-1:0] bck_ff, lrck_ff, sdata_ff;
  logic                   bck_prev;
  logic                   bck_s, lrck_s, sdata_s;
  logic                   bck_rise, lrck_chg;

  state_t                 state;
  logic                   lrck_prev;
  logic [CW-1:0]          cnt, cnt_inc;
  logic [DATA_WIDTH-1:0]  sr, sr_next, l_hold;

  // Synchronisers keep running while run is low so bck edge tracking stays coherent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bck_ff   <= '0;
      lrck_ff  <= '0;
      sdata_ff <= '0;
      bck_prev <= 1'b0;
    end else begin
      bck_ff   <= {bck_ff[SYNC_STAGES-2:0], i2s_bck};
      lrck_ff  <= {lrck_ff[SYNC_STAGES-2:0], i2s_lrck};
      sdata_ff <= {sdata_ff[SYNC_STAGES-2:0], i2s_sdata};
      bck_prev <= bck_ff[SYNC_STAGES-1];
    end
  end

  assign bck_s    = bck_ff[SYNC_STAGES-1];
  assign lrck_s   = lrck_ff[SYNC_STAGES-1];
  assign sdata_s  = sdata_ff[SYNC_STAGES-1];
  assign bck_rise = bck_s & ~bck_prev;
  assign lrck_chg = bck_rise & (lrck_s != lrck_prev);
  assign cnt_inc  = (cnt == CW'(MAX_SLOT)) ? cnt : cnt + CW'(1);

  // Bit n of the slot lands at position DATA_WIDTH-1-n, so short slots come out left-justified.
  always_comb begin
    sr_next = sr;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (cnt == CW'(DATA_WIDTH - 1 - i)) sr_next[i] = sdata_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ALIGN;
      lrck_prev  <= 1'b0;
      cnt        <= '0;
      sr         <= '0;
      l_hold     <= '0;
      pcm_valid  <= 1'b0;
      l_pcm_data <= '0;
      r_pcm_data <= '0;
    end else if (!run) begin
      state      <= ALIGN;
      lrck_prev  <= 1'b0;
      cnt        <= '0;
      sr         <= '0;
      l_hold     <= '0;
      pcm_valid  <= 1'b0;
      l_pcm_data <= '0;
      r_pcm_data <= '0;
    end else begin
      pcm_valid <= 1'b0;
      if (bck_rise) begin
        lrck_prev <= lrck_s;
        if (lrck_chg) begin
          sr  <= '0;
          cnt <= '0;
        end else begin
          sr  <= sr_next;
          cnt <= cnt_inc;
        end
      end
      // The bit sampled on an lrck change still belongs to the outgoing slot, hence sr_next.
      if (lrck_chg) begin
        case (state)
          ALIGN: if (!lrck_s) state <= LEFT;
          LEFT: begin
            l_hold <= sr_next;
            state  <= RIGHT;
          end
          RIGHT: begin
            l_pcm_data <= l_hold;
            r_pcm_data <= sr_next;
            pcm_valid  <= 1'b1;
            state      <= LEFT;
          end
          default: state <= ALIGN;
        endcase
      end
    end
  end

`ifdef PCM_SLOT_ERR_EN
  logic          err_q;
  logic [CW-1:0] l_cnt;
  logic          short_slot;

  // cnt on the closing rise is one less than the number of bits in the slot.
  assign short_slot = (cnt < CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
      l_cnt <= '0;
    end else if (!run) begin
      err_q <= 1'b0;
      l_cnt <= '0;
    end else if (lrck_chg) begin
      if (state == LEFT) begin
        l_cnt <= cnt;
        if (short_slot) err_q <= 1'b1;
      end else if (state == RIGHT) begin
        if (short_slot || (cnt != l_cnt)) err_q <= 1'b1;
      end
    end
  end

  assign slot_err = err_q;
`else
  assign slot_err = 1'b0;
`endif

endmodule

// File: tb/tb_pcm_i2s_receiver.sv
// Scoreboard bench for pcm_i2s_receiver: random I2S frames against a word-level reference model.
`timescale 1ns/1ps
module tb_pcm_i2s_receiver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic        i2s_bck = 1'b0;
  logic        i2s_lrck = 1'b0;
  logic        i2s_sdata = 1'b0;
  logic        pcm_valid;
  logic [23:0] l_pcm_data, r_pcm_data;
  logic        slot_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          vcount = 0;
  int          v0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_exp;
  logic        prev_last = 1'b0;
  logic        last_valid = 1'b0;
  logic [23:0] last_l = '0, last_r = '0;
  logic [23:0] wl, wr;

`ifdef PCM_SLOT_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  pcm_i2s_receiver dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .run        (run),
    .i2s_bck    (i2s_bck),
    .i2s_lrck   (i2s_lrck),
    .i2s_sdata  (i2s_sdata),
    .pcm_valid  (pcm_valid),
    .l_pcm_data (l_pcm_data),
    .r_pcm_data (r_pcm_data),
    .slot_err   (slot_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
  endtask

  // Monitor: pops the scoreboard on every strobe; outputs may only change on a strobe or clear to 0.
  always @(negedge clk) begin
    if (pcm_valid === 1'b1) begin
      vcount++;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {l_pcm_data, r_pcm_data}, 48'hx);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pcm_pair", {l_pcm_data, r_pcm_data}, mon_exp);
      end
      if (last_valid) check("pulse_width", 48'(last_valid), 48'(1'b0));
    end else if ({l_pcm_data, r_pcm_data} != {last_l, last_r} && {l_pcm_data, r_pcm_data} != 48'h0) begin
      check("hold_between_strobes", {l_pcm_data, r_pcm_data}, {last_l, last_r});
    end
    last_valid = pcm_valid;
    last_l     = l_pcm_data;
    last_r     = r_pcm_data;
  end

  // Reference model: slot keeps its first min(n,24) bits, the rest reads as zero.
  function automatic logic [23:0] expect_word(input logic [23:0] w, input int n);
    logic [23:0] m;
    m = (n >= 24) ? 24'hFFFFFF : ~(24'hFFFFFF >> n);
    return w & m;
  endfunction

  function automatic logic slot_bit(input logic [23:0] w, input int k, input logic trail);
    return (k < 24) ? w[23 - k] : trail;
  endfunction

  task automatic send_bit(input logic lr, input logic d, input int h, input bit drop);
    i2s_lrck  = lr;
    i2s_sdata = d;
    #h;
    i2s_bck = 1'b1;
    if (drop) begin
      #10;
      run = 1'b0;
      #50;
      run = 1'b1;
    end
    #h;
    i2s_bck = 1'b0;
  endtask

  // 1-bit delay: the first bit under the new lrck level is the previous slot's last bit.
  task automatic send_slot(input logic lr, input logic [23:0] w, input int n, input logic trail,
                           input int h, input int drop_at);
    send_bit(lr, prev_last, h, 1'b0);
    for (int k = 0; k < n - 1; k++) send_bit(lr, slot_bit(w, k, trail), h, k == drop_at);
    prev_last = slot_bit(w, n - 1, trail);
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int n, input logic trail,
                            input int h, input bit push, input int drop_at);
    if (push) exp_q.push_back({expect_word(l, n), expect_word(r, n)});
    send_slot(1'b0, l, n, trail, h, -1);
    send_slot(1'b1, r, n, trail, h, drop_at);
  endtask

  task automatic start_stream(input int h);
    prev_last = 1'b0;
    send_bit(1'b1, 1'b0, h, 1'b0);
    send_bit(1'b1, 1'b0, h, 1'b0);
  endtask

  task automatic end_stream(input int h);
    send_bit(1'b0, prev_last, h, 1'b0);
    repeat (10) @(posedge clk);
    #2;
  endtask

  task automatic restart();
    run = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    run = 1'b1;
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, queue depth %0d", exp_q.size());
    miscompares++;
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and alignment
    repeat (3) @(posedge clk);
    #2;
    check("reset_data", {l_pcm_data, r_pcm_data}, 48'h0);
    check("reset_valid_err", 48'({pcm_valid, slot_err}), 48'h0);
    reset_n = 1'b1;
    run     = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    v0 = vcount;
    start_stream(30);
    send_frame(24'h123456, 24'hABCDEF, 32, 1'b0, 30, 1'b1, -1);
    check("pre_align_data", {l_pcm_data, r_pcm_data}, 48'h0);
    check("pre_align_count", 48'(vcount - v0), 48'd0);
    repeat (3) send_frame(24'h123456, 24'hABCDEF, 32, 1'b0, 30, 1'b1, -1);
    end_stream(30);
    check("align_frames", 48'(vcount - v0), 48'd4);
    check("align_slot_err", 48'(slot_err), 48'd0);

    // Bit ordering and sign, trailing ones ignored
    restart();
    v0 = vcount;
    start_stream(20);
    repeat (3) send_frame(24'h800000, 24'h7FFFFF, 32, 1'b1, 20, 1'b1, -1);
    end_stream(20);
    check("sign_frames", 48'(vcount - v0), 48'd3);
    check("sign_slot_err", 48'(slot_err), 48'd0);

    // Short 16-bit slots
    restart();
    v0 = vcount;
    start_stream(30);
    send_frame(24'hBEEF00, 24'h123400, 16, 1'b0, 30, 1'b1, -1);
    send_frame(24'hBEEF00, 24'h123400, 16, 1'b0, 30, 1'b1, -1);
    check("short_slot_err_first", 48'(slot_err), 48'(ERR_EN));
    send_frame(24'hBEEF00, 24'h123400, 16, 1'b0, 30, 1'b1, -1);
    end_stream(30);
    check("short_frames", 48'(vcount - v0), 48'd3);
    check("short_slot_err_sticky", 48'(slot_err), 48'(ERR_EN));
    restart();
    check("slot_err_run_clear", 48'(slot_err), 48'd0);

    // Run drop during the 10th bit of a right slot (24-bit slots)
    v0 = vcount;
    start_stream(30);
    send_frame(24'($urandom()), 24'($urandom()), 24, 1'b0, 30, 1'b1, -1);
    send_frame(24'($urandom()), 24'($urandom()), 24, 1'b0, 30, 1'b0, 9);
    send_frame(24'($urandom()), 24'($urandom()), 24, 1'b0, 30, 1'b1, -1);
    send_frame(24'($urandom()), 24'($urandom()), 24, 1'b0, 30, 1'b1, -1);
    end_stream(30);
    check("run_drop_frames", 48'(vcount - v0), 48'd3);
    check("run_drop_slot_err", 48'(slot_err), 48'd0);

    // Max rate: bck = clk/4, 100 random frames
    restart();
    v0 = vcount;
    start_stream(20);
    for (int f = 0; f < 100; f++) begin
      wl = 24'($urandom());
      wr = 24'($urandom());
      send_frame(wl, wr, 32, 1'($urandom_range(0, 1)), 20, 1'b1, -1);
    end
    end_stream(20);
    check("max_rate_frames", 48'(vcount - v0), 48'd100);
    check("max_rate_slot_err", 48'(slot_err), 48'd0);

    // Asynchronous reset mid-slot
    restart();
    v0 = vcount;
    start_stream(30);
    send_frame(24'($urandom()) | 24'h1, 24'($urandom()) | 24'h1, 32, 1'b0, 30, 1'b1, -1);
    send_bit(1'b0, prev_last, 30, 1'b0);
    for (int k = 0; k < 4; k++) send_bit(1'b0, 1'($urandom_range(0, 1)), 30, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_data", {l_pcm_data, r_pcm_data}, 48'h0);
    check("async_reset_valid_err", 48'({pcm_valid, slot_err}), 48'h0);
    #9;
    reset_n = 1'b1;
    for (int k = 4; k < 31; k++) send_bit(1'b0, 1'($urandom_range(0, 1)), 30, 1'b0);
    prev_last = 1'($urandom_range(0, 1));
    send_slot(1'b1, 24'($urandom()), 32, 1'b0, 30, -1);
    send_frame(24'($urandom()), 24'($urandom()), 32, 1'b0, 30, 1'b1, -1);
    send_frame(24'($urandom()), 24'($urandom()), 32, 1'b0, 30, 1'b1, -1);
    end_stream(30);
    check("async_reset_frames", 48'(vcount - v0), 48'd3);

    check("scoreboard_drained", 48'(exp_q.size()), 48'd0);
    summary();
    $finish;
  end

endmodule
